// File: rtl/fifo_ctrl_lvl.sv
// FIFO pointer/flag controller for arbitrary depth (>= 2) with occupancy count,
// programmable almost-full/almost-empty levels, synchronous flush and sticky error flags.
module fifo_ctrl_lvl #(
  parameter int DEPTH      = 16,
  parameter int AFULL_LVL  = 14,
  parameter int AEMPTY_LVL = 2,
  localparam int AW = ($clog2(DEPTH) < 1) ? 1 : $clog2(DEPTH),
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          flush_i,
  input  logic          wr_i,
  input  logic          rd_i,
  output logic          wr_en_o,
  output logic          rd_en_o,
  output logic [AW-1:0] w_addr_o,
  output logic [AW-1:0] r_addr_o,
  output logic [CW-1:0] count_o,
  output logic          empty_o,
  output logic          full_o,
  output logic          almost_empty_o,
  output logic          almost_full_o,
  output logic          overflow_o,
  output logic          underflow_o
);

  localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);
  localparam logic [CW-1:0] DEPTH_C   = CW'(DEPTH);
  localparam logic [CW-1:0] AFULL_C   = CW'(AFULL_LVL);
  localparam logic [CW-1:0] AEMPTY_C  = CW'(AEMPTY_LVL);

  logic          accept_ok;
  logic [CW-1:0] count_nxt;
  logic [AW-1:0] w_addr_nxt;
  logic [AW-1:0] r_addr_nxt;

  // A write into a full FIFO is still taken when a read frees the slot in the same cycle.
  always_comb begin
    accept_ok  = ~rst_i & ~flush_i;
    wr_en_o    = wr_i & accept_ok & (~full_o | rd_i);
    rd_en_o    = rd_i & accept_ok & ~empty_o;
    count_nxt  = '0;
    w_addr_nxt = '0;
    r_addr_nxt = '0;
    if (accept_ok) begin
      count_nxt  = count_o + CW'(wr_en_o) - CW'(rd_en_o);
      w_addr_nxt = w_addr_o;
      r_addr_nxt = r_addr_o;
      if (wr_en_o) begin
        w_addr_nxt = (w_addr_o == LAST_ADDR) ? '0 : w_addr_o + AW'(1);
      end
      if (rd_en_o) begin
        r_addr_nxt = (r_addr_o == LAST_ADDR) ? '0 : r_addr_o + AW'(1);
      end
    end
  end

  // Flags come from the next count so they move on the same edge as count_o.
  always_ff @(posedge clk_i) begin
    w_addr_o       <= w_addr_nxt;
    r_addr_o       <= r_addr_nxt;
    count_o        <= count_nxt;
    empty_o        <= (count_nxt == '0);
    full_o         <= (count_nxt == DEPTH_C);
    almost_full_o  <= (count_nxt >= AFULL_C);
    almost_empty_o <= (count_nxt <= AEMPTY_C);
    if (rst_i || flush_i) begin
      overflow_o  <= 1'b0;
      underflow_o <= 1'b0;
    end else begin
      overflow_o  <= overflow_o | (wr_i & ~wr_en_o);
      underflow_o <= underflow_o | (rd_i & ~rd_en_o);
    end
  end

endmodule

// File: tb/tb_fifo_ctrl_lvl.sv
// Bench for fifo_ctrl_lvl: directed vector table on a depth-5 instance plus a
// scoreboard-checked random soak on a depth-16 instance.
module tb_fifo_ctrl_lvl;

  localparam logic H = 1'b1;
  localparam logic L = 1'b0;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int assert_count = 0;
  int fail_count   = 0;

  // depth-5 instance
  logic       rst = 1'b1, flush = 1'b0, wr = 1'b0, rd = 1'b0;
  logic       wr_en, rd_en, empty, full, aempty, afull, ovf, unf;
  logic [2:0] w_addr, r_addr, count;
  logic       got_wr_en, got_rd_en;

  fifo_ctrl_lvl #(.DEPTH(5), .AFULL_LVL(4), .AEMPTY_LVL(1)) dut5 (
    .clk_i(clk), .rst_i(rst), .flush_i(flush), .wr_i(wr), .rd_i(rd),
    .wr_en_o(wr_en), .rd_en_o(rd_en), .w_addr_o(w_addr), .r_addr_o(r_addr),
    .count_o(count), .empty_o(empty), .full_o(full),
    .almost_empty_o(aempty), .almost_full_o(afull),
    .overflow_o(ovf), .underflow_o(unf)
  );

  // depth-16 instance
  logic       s_rst = 1'b1, s_flush = 1'b0, s_wr = 1'b0, s_rd = 1'b0;
  logic       s_wr_en, s_rd_en, s_empty, s_full, s_aempty, s_afull, s_ovf, s_unf;
  logic [3:0] s_w_addr, s_r_addr;
  logic [4:0] s_count;

  fifo_ctrl_lvl #(.DEPTH(16), .AFULL_LVL(14), .AEMPTY_LVL(2)) dut16 (
    .clk_i(clk), .rst_i(s_rst), .flush_i(s_flush), .wr_i(s_wr), .rd_i(s_rd),
    .wr_en_o(s_wr_en), .rd_en_o(s_rd_en), .w_addr_o(s_w_addr), .r_addr_o(s_r_addr),
    .count_o(s_count), .empty_o(s_empty), .full_o(s_full),
    .almost_empty_o(s_aempty), .almost_full_o(s_afull),
    .overflow_o(s_ovf), .underflow_o(s_unf)
  );

  typedef struct {
    logic rst, flush, wr, rd;
    logic wr_en, rd_en;
    int   count, w_addr, r_addr;
    logic empty, full, ae, af, ovf, unf;
  } vec_t;

  vec_t vecs[22];

  // Compares one observed value against its expected value and tallies the result.
  task automatic checkOutput(input string name, input int act, input int exp);
    assert_count++;
    if (act != exp) begin
      fail_count++;
      $display("[TB] FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
    end
  endtask

  // Drives one cycle on the depth-5 instance, captures the strobes before the
  // edge and returns just after the edge so registered outputs can be checked.
  task automatic applyStimulus(input logic r, input logic f, input logic w, input logic d);
    @(negedge clk);
    rst = r; flush = f; wr = w; rd = d;
    #1;
    got_wr_en = wr_en;
    got_rd_en = rd_en;
    @(posedge clk);
    #1;
  endtask

  int mem[16];
  int q[$];
  int next_data;
  int exp_data;
  int wr_bias;
  logic want_wr, want_rd;

  initial begin
    // rst flush wr rd | wr_en rd_en | count w r | empty full ae af ovf unf
    vecs[0]  = '{H,L,L,L, L,L, 0,0,0, H,L,H,L,L,L};
    vecs[1]  = '{L,L,H,L, H,L, 1,1,0, L,L,H,L,L,L};
    vecs[2]  = '{L,L,H,L, H,L, 2,2,0, L,L,L,L,L,L};
    vecs[3]  = '{L,L,H,L, H,L, 3,3,0, L,L,L,L,L,L};
    vecs[4]  = '{L,L,H,L, H,L, 4,4,0, L,L,L,H,L,L};
    vecs[5]  = '{L,L,H,L, H,L, 5,0,0, L,H,L,H,L,L};
    vecs[6]  = '{L,L,H,L, L,L, 5,0,0, L,H,L,H,H,L};
    vecs[7]  = '{L,L,H,H, H,H, 5,1,1, L,H,L,H,H,L};
    vecs[8]  = '{L,L,L,H, L,H, 4,1,2, L,L,L,H,H,L};
    vecs[9]  = '{L,L,L,H, L,H, 3,1,3, L,L,L,L,H,L};
    vecs[10] = '{L,L,L,H, L,H, 2,1,4, L,L,L,L,H,L};
    vecs[11] = '{L,L,L,H, L,H, 1,1,0, L,L,H,L,H,L};
    vecs[12] = '{L,L,L,H, L,H, 0,1,1, H,L,H,L,H,L};
    vecs[13] = '{L,L,H,H, H,L, 1,2,1, L,L,H,L,H,H};
    vecs[14] = '{L,L,H,L, H,L, 2,3,1, L,L,L,L,H,H};
    vecs[15] = '{L,L,H,L, H,L, 3,4,1, L,L,L,L,H,H};
    vecs[16] = '{L,H,H,L, L,L, 0,0,0, H,L,H,L,L,L};
    vecs[17] = '{L,L,H,L, H,L, 1,1,0, L,L,H,L,L,L};
    vecs[18] = '{L,L,H,L, H,L, 2,2,0, L,L,L,L,L,L};
    vecs[19] = '{H,L,H,H, L,L, 0,0,0, H,L,H,L,L,L};
    vecs[20] = '{L,L,L,H, L,L, 0,0,0, H,L,H,L,L,H};
    vecs[21] = '{L,H,L,H, L,L, 0,0,0, H,L,H,L,L,L};

    $display("[TB] directed vectors on depth-5 instance");
    for (int i = 0; i < 22; i++) begin
      applyStimulus(vecs[i].rst, vecs[i].flush, vecs[i].wr, vecs[i].rd);
      checkOutput($sformatf("v%0d wr_en", i),  got_wr_en, vecs[i].wr_en);
      checkOutput($sformatf("v%0d rd_en", i),  got_rd_en, vecs[i].rd_en);
      checkOutput($sformatf("v%0d count", i),  count,     vecs[i].count);
      checkOutput($sformatf("v%0d w_addr", i), w_addr,    vecs[i].w_addr);
      checkOutput($sformatf("v%0d r_addr", i), r_addr,    vecs[i].r_addr);
      checkOutput($sformatf("v%0d empty", i),  empty,     vecs[i].empty);
      checkOutput($sformatf("v%0d full", i),   full,      vecs[i].full);
      checkOutput($sformatf("v%0d aempty", i), aempty,    vecs[i].ae);
      checkOutput($sformatf("v%0d afull", i),  afull,     vecs[i].af);
      checkOutput($sformatf("v%0d ovf", i),    ovf,       vecs[i].ovf);
      checkOutput($sformatf("v%0d unf", i),    unf,       vecs[i].unf);
    end

    // Freed slot: a read out of full lets a write in on the very next cycle.
    for (int i = 0; i < 5; i++) applyStimulus(L, L, H, L);
    checkOutput("fill full", full, 1);
    checkOutput("fill count", count, 5);
    applyStimulus(L, L, L, H);
    checkOutput("freed rd_en", got_rd_en, 1);
    checkOutput("freed full", full, 0);
    checkOutput("freed count", count, 4);
    applyStimulus(L, L, H, L);
    checkOutput("refill wr_en", got_wr_en, 1);
    checkOutput("refill full", full, 1);
    checkOutput("refill ovf", ovf, 0);
    applyStimulus(H, L, L, L);

    $display("[TB] random soak on depth-16 instance");
    @(negedge clk);
    s_rst = 1'b0;
    next_data = 1;
    for (int cyc = 0; cyc < 10000; cyc++) begin
      wr_bias = ((cyc / 400) % 2 == 0) ? 75 : 25;
      want_wr = ($urandom_range(99) < wr_bias);
      want_rd = ($urandom_range(99) < (100 - wr_bias));
      @(negedge clk);
      s_rd = want_rd && (q.size() > 0);
      s_wr = want_wr && ((q.size() < 16) || s_rd);
      #1;
      checkOutput("soak wr_en", s_wr_en, s_wr);
      checkOutput("soak rd_en", s_rd_en, s_rd);
      if (s_rd) begin
        exp_data = q.pop_front();
        checkOutput("soak data", mem[s_r_addr], exp_data);
      end
      if (s_wr) begin
        mem[s_w_addr] = next_data;
        q.push_back(next_data);
        next_data++;
      end
      @(posedge clk);
      #1;
      checkOutput("soak count",  s_count,  q.size());
      checkOutput("soak empty",  s_empty,  q.size() == 0);
      checkOutput("soak full",   s_full,   q.size() == 16);
      checkOutput("soak afull",  s_afull,  q.size() >= 14);
      checkOutput("soak aempty", s_aempty, q.size() <= 2);
      checkOutput("soak ovf",    s_ovf,    0);
      checkOutput("soak unf",    s_unf,    0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", assert_count, fail_count);
    $finish;
  end

endmodule
